// File: rtl/trigger_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trigger_reset_sequencer
// Purpose  : Trigger-mode release of DAC and RAM-writer resets, with watchdog
//            supervision and a sticky fault state. Optional build macro
//            TRIGGER_RESET_SEQUENCER_INSTANT_RESET_EN adds instant_reset_in.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_reset_sequencer #(
    parameter int RAMWRITER_DELAY_CYCLES  = 125000,
    parameter int WATCHDOG_TIMEOUT_CYCLES = 12500000,
    parameter int CNT_WIDTH               = 28
) (
    input  logic       clk,
    input  logic       peripheral_aresetn,
    input  logic       seq_enable,
    input  logic       watchdog_enable,
    input  logic       trigger_in,
    input  logic       watchdog_in,
    input  logic       clear_fault,
    output logic       dac_aresetn,
    output logic       ram_writer_aresetn,
    output logic       reset_ack,
    output logic [2:0] seq_state,
    output logic [7:0] fault_count
`ifdef TRIGGER_RESET_SEQUENCER_INSTANT_RESET_EN
    ,
    input  logic       instant_reset_in
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DAC_RUN = 3'd2,
        S_RUN     = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_DELAY_LOAD = CNT_WIDTH'(RAMWRITER_DELAY_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_WD_LAST    = CNT_WIDTH'(WATCHDOG_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_trig_prev;
    logic                 r_wd_prev;
    logic [CNT_WIDTH-1:0] r_delay_cnt;
    logic [CNT_WIDTH-1:0] w_delay_nxt;
    logic [CNT_WIDTH-1:0] r_wd_cnt;
    logic [CNT_WIDTH-1:0] w_wd_nxt;
    logic                 w_trig_rise;
    logic                 w_wd_edge;
    logic                 w_running;
    logic                 w_timeout;
    logic                 w_force_fault;

    assign w_trig_rise = trigger_in & ~r_trig_prev;
    assign w_wd_edge   = watchdog_in ^ r_wd_prev;
    assign w_running   = (r_state == S_DAC_RUN) || (r_state == S_RUN);
    // An edge arriving on the would-be timeout cycle rescues the run.
    assign w_timeout   = w_running && watchdog_enable && !w_wd_edge && (r_wd_cnt == c_WD_LAST);

`ifdef TRIGGER_RESET_SEQUENCER_INSTANT_RESET_EN
    assign w_force_fault = w_timeout || (w_running && instant_reset_in);
`else
    assign w_force_fault = w_timeout;
`endif

    assign seq_state = r_state;

    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            r_state     <= S_IDLE;
            r_trig_prev <= 1'b0;
            r_wd_prev   <= 1'b0;
            r_delay_cnt <= '0;
            r_wd_cnt    <= '0;
        end else begin
            r_state     <= w_next;
            r_trig_prev <= trigger_in;
            r_wd_prev   <= watchdog_in;
            r_delay_cnt <= w_delay_nxt;
            r_wd_cnt    <= w_wd_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_delay_nxt = r_delay_cnt;
        w_wd_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (seq_enable) begin
                    w_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!seq_enable) begin
                    w_next = S_IDLE;
                end else if (w_trig_rise) begin
                    w_next      = S_DAC_RUN;
                    w_delay_nxt = c_DELAY_LOAD;
                end
            end
            S_DAC_RUN, S_RUN: begin
                if (watchdog_enable && !w_wd_edge) begin
                    w_wd_nxt = r_wd_cnt + c_CNT_ONE;
                end
                if ((r_state == S_DAC_RUN) && (r_delay_cnt != '0)) begin
                    w_delay_nxt = r_delay_cnt - c_CNT_ONE;
                end
                if (w_force_fault) begin
                    w_next = S_FAULT;
                end else if (!seq_enable || !trigger_in) begin
                    w_next = S_IDLE;
                end else if ((r_state == S_DAC_RUN) && (r_delay_cnt == '0)) begin
                    w_next = S_RUN;
                end
            end
            S_FAULT: begin
                if (clear_fault && !trigger_in) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land on the same edge as the state.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            dac_aresetn        <= 1'b0;
            ram_writer_aresetn <= 1'b0;
            reset_ack          <= 1'b0;
            fault_count        <= 8'd0;
        end else begin
            dac_aresetn        <= (w_next == S_DAC_RUN) || (w_next == S_RUN);
            ram_writer_aresetn <= (w_next == S_RUN);
            reset_ack          <= (w_next == S_FAULT);
            if ((w_next == S_FAULT) && (r_state != S_FAULT) && (fault_count != 8'hFF)) begin
                fault_count <= fault_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
